// File: rtl/iomem_timer_pkg.sv
// rtl/iomem_timer_pkg.sv - register map, bit indices and bus FSM type for iomem_timer
package iomem_timer_pkg;

    localparam logic [7:0] OFF_CTRL     = 8'h00;
    localparam logic [7:0] OFF_PRESCALE = 8'h04;
    localparam logic [7:0] OFF_COUNT    = 8'h08;
    localparam logic [7:0] OFF_COMPARE  = 8'h0C;
    localparam logic [7:0] OFF_STATUS   = 8'h10;
    localparam logic [7:0] OFF_DUTY     = 8'h14;

    localparam int CTRL_EN          = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_IRQ_EN      = 2;
    localparam int STATUS_MATCH     = 0;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_ACK  = 1'b1
    } bus_state_e;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] cur,
        input logic [31:0] wdata,
        input logic [3:0]  wstrb
    );
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = wstrb[b] ? wdata[b*8 +: 8] : cur[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/iomem_timer_prescaler.sv
// rtl/iomem_timer_prescaler.sv - clock divider producing one tick every div+1 enabled clocks
module timer_prescaler
    import iomem_timer_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      en,
    input  logic                      clear,
    input  logic [PRESCALE_WIDTH-1:0] div,
    output logic                      tick
);

    logic [PRESCALE_WIDTH-1:0] pcnt_q;

    assign tick = en && (pcnt_q == div);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pcnt_q <= '0;
        end else if (!en || clear || tick) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/iomem_timer.sv
// rtl/iomem_timer.sv - iomem-mapped prescaled compare timer; TIMER_PWM_EN adds DUTY register and pwm_out
module iomem_timer
    import iomem_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0300_0000,
    parameter int          COUNT_WIDTH    = 32,
    parameter int          PRESCALE_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    input  logic [3:0]  iomem_wstrb,
    output logic [31:0] iomem_rdata,
    output logic        irq,
    output logic        pwm_out
);

    bus_state_e state_q, state_d;

    logic                      win_hit;
    logic                      accept;
    logic                      is_write;
    logic [7:0]                offset;
    logic [31:0]               rd_val;
    logic [31:0]               wr_val;
    logic [31:0]               rdata_q;

    logic [2:0]                ctrl_q;
    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic [COUNT_WIDTH-1:0]    count_q;
    logic [COUNT_WIDTH-1:0]    compare_q;
    logic                      match_q;

    logic wr_ctrl, wr_prescale, wr_count, wr_compare, wr_status;
    logic tick, cmp_hit, w1c_match;

    assign offset   = iomem_addr[7:0];
    assign win_hit  = (iomem_addr[31:8] == BASE_ADDR[31:8]);
    assign is_write = |iomem_wstrb;
    assign accept   = (state_q == BUS_IDLE) && iomem_valid && win_hit;

    assign wr_ctrl     = accept && is_write && (offset == OFF_CTRL);
    assign wr_prescale = accept && is_write && (offset == OFF_PRESCALE);
    assign wr_count    = accept && is_write && (offset == OFF_COUNT);
    assign wr_compare  = accept && is_write && (offset == OFF_COMPARE);
    assign wr_status   = accept && is_write && (offset == OFF_STATUS);
    // W1C looks only at the raw strobed byte; merging with the current value would self-clear
    assign w1c_match   = wr_status && iomem_wstrb[0] && iomem_wdata[STATUS_MATCH];

`ifdef TIMER_PWM_EN
    logic [COUNT_WIDTH-1:0] duty_q;
    logic                   pwm_q;
    logic                   wr_duty;

    assign wr_duty = accept && is_write && (offset == OFF_DUTY);
`endif

    always_comb begin
        rd_val = '0;
        case (offset)
            OFF_CTRL:     rd_val[2:0] = ctrl_q;
            OFF_PRESCALE: rd_val[PRESCALE_WIDTH-1:0] = prescale_q;
            OFF_COUNT:    rd_val[COUNT_WIDTH-1:0] = count_q;
            OFF_COMPARE:  rd_val[COUNT_WIDTH-1:0] = compare_q;
            OFF_STATUS:   rd_val[STATUS_MATCH] = match_q;
`ifdef TIMER_PWM_EN
            OFF_DUTY:     rd_val[COUNT_WIDTH-1:0] = duty_q;
`endif
            default:      rd_val = '0;
        endcase
    end

    // Byte strobes merge into the addressed register's current (zero-extended) value
    assign wr_val = byte_merge(rd_val, iomem_wdata, iomem_wstrb);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= BUS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BUS_IDLE: if (iomem_valid && win_hit) state_d = BUS_ACK;
            BUS_ACK:  state_d = BUS_IDLE;
            default:  state_d = BUS_IDLE;
        endcase
    end

    assign iomem_ready = (state_q == BUS_ACK);
    assign iomem_rdata = rdata_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_q <= '0;
        end else if (accept) begin
            rdata_q <= rd_val;
        end
    end

    timer_prescaler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_prescaler (
        .clk   (clk),
        .rstn  (rstn),
        .en    (ctrl_q[CTRL_EN]),
        .clear (wr_prescale),
        .div   (prescale_q),
        .tick  (tick)
    );

    assign cmp_hit = (count_q == compare_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            match_q    <= 1'b0;
        end else begin
            if (wr_prescale) prescale_q <= wr_val[PRESCALE_WIDTH-1:0];
            if (wr_compare)  compare_q  <= wr_val[COUNT_WIDTH-1:0];

            // Bus writes take priority over the tick's update of the same register
            if (wr_ctrl) begin
                ctrl_q <= wr_val[2:0];
            end else if (tick && cmp_hit && !ctrl_q[CTRL_AUTO_RELOAD]) begin
                ctrl_q[CTRL_EN] <= 1'b0;
            end

            if (wr_count) begin
                count_q <= wr_val[COUNT_WIDTH-1:0];
            end else if (tick) begin
                if (cmp_hit) begin
                    if (ctrl_q[CTRL_AUTO_RELOAD]) count_q <= '0;
                end else begin
                    count_q <= count_q + 1'b1;
                end
            end

            if (tick && cmp_hit) begin
                match_q <= 1'b1;
            end else if (w1c_match) begin
                match_q <= 1'b0;
            end
        end
    end

    assign irq = match_q && ctrl_q[CTRL_IRQ_EN];

`ifdef TIMER_PWM_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            duty_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            if (wr_duty) duty_q <= wr_val[COUNT_WIDTH-1:0];
            pwm_q <= ctrl_q[CTRL_EN] && (count_q < duty_q);
        end
    end

    assign pwm_out = pwm_q;
`else
    assign pwm_out = 1'b0;
`endif

endmodule

// File: tb/tb_iomem_timer.sv
// tb/tb_iomem_timer.sv - directed self-checking bench for iomem_timer
module tb_iomem_timer;

    localparam logic [31:0] BASE = 32'h0300_0000;
    localparam logic [31:0] A_CTRL     = BASE + 32'h00;
    localparam logic [31:0] A_PRESCALE = BASE + 32'h04;
    localparam logic [31:0] A_COUNT    = BASE + 32'h08;
    localparam logic [31:0] A_COMPARE  = BASE + 32'h0C;
    localparam logic [31:0] A_STATUS   = BASE + 32'h10;
    localparam logic [31:0] A_DUTY     = BASE + 32'h14;
    localparam logic [31:0] A_HOLE     = BASE + 32'h20;

    logic        clk = 1'b0;
    logic        rstn;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_rdata;
    logic        irq;
    logic        pwm_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iomem_timer dut (
        .clk         (clk),
        .rstn        (rstn),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_wstrb (iomem_wstrb),
        .iomem_rdata (iomem_rdata),
        .irq         (irq),
        .pwm_out     (pwm_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; request is seen at the next posedge, ready must follow one cycle later
    task automatic access(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, output logic [31:0] rdata);
        int n;
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wdata = wdata;
        iomem_wstrb = wstrb;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!iomem_ready && n < 8);
        check("ready_latency", n, 1);
        rdata = iomem_rdata;
        @(posedge clk);
        #1;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        @(negedge clk);
        check("ready_one_cycle", {31'b0, iomem_ready}, 32'h0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] dummy;
        access(addr, data, 4'hF, dummy);
    endtask

    task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] val;
        access(addr, 32'h0, 4'h0, val);
        check(tag, val, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] dummy;
        int pwm_high;

        rstn        = 1'b0;
        iomem_valid = 1'b0;
        iomem_addr  = 32'h0;
        iomem_wdata = 32'h0;
        iomem_wstrb = 4'h0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'b0, iomem_ready}, 32'h0);
        check("rst_rdata", iomem_rdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_pwm", {31'b0, pwm_out}, 32'h0);
        rstn = 1'b1;
        @(negedge clk);

        rd_check("rst_ctrl", A_CTRL, 32'h0);
        rd_check("rst_count", A_COUNT, 32'h0);
        rd_check("rst_status", A_STATUS, 32'h0);
        check("rst_irq2", {31'b0, irq}, 32'h0);

        // Auto-reload: ticks every 4 clocks, match on the 6th tick = 24 clocks after EN
        wr(A_PRESCALE, 32'd3);
        wr(A_COMPARE, 32'd5);
        wr(A_CTRL, 32'h7);
        repeat (22) @(negedge clk);
        check("irq_before_match", {31'b0, irq}, 32'h0);
        @(negedge clk);
        check("irq_at_match", {31'b0, irq}, 32'h1);
        rd_check("ar_count_reload", A_COUNT, 32'h0);
        rd_check("ar_status", A_STATUS, 32'h1);
        rd_check("ar_count_running", A_COUNT, 32'h1);

        wr(A_CTRL, 32'h0);
        wr(A_STATUS, 32'h1);
        rd_check("ar_status_clr", A_STATUS, 32'h0);
        check("ar_irq_clr", {31'b0, irq}, 32'h0);
        wr(A_COUNT, 32'h0);

        // One-shot
        wr(A_PRESCALE, 32'd0);
        wr(A_COMPARE, 32'd2);
        wr(A_CTRL, 32'h1);
        repeat (4) @(negedge clk);
        rd_check("os_ctrl", A_CTRL, 32'h0);
        rd_check("os_count", A_COUNT, 32'h2);
        rd_check("os_status", A_STATUS, 32'h1);
        check("os_irq_masked", {31'b0, irq}, 32'h0);
        wr(A_STATUS, 32'h1);
        rd_check("os_w1c", A_STATUS, 32'h0);

        // Byte strobes and unmapped offset
        wr(A_COMPARE, 32'hFFFF_FFFF);
        access(A_COMPARE, 32'h0000_1200, 4'b0010, dummy);
        rd_check("strb_compare", A_COMPARE, 32'hFFFF_12FF);
        wr(A_HOLE, 32'hDEAD_BEEF);
        rd_check("hole_read", A_HOLE, 32'h0);

        // COUNT write collides with a tick (prescale 0 ticks every clock)
        wr(A_COUNT, 32'h0);
        wr(A_COMPARE, 32'h100);
        wr(A_CTRL, 32'h1);
        wr(A_COUNT, 32'h10);
        wr(A_CTRL, 32'h0);
        rd_check("coll_count", A_COUNT, 32'h12);

        // W1C lands on the same edge as a match
        wr(A_COUNT, 32'h0);
        wr(A_COMPARE, 32'd3);
        wr(A_CTRL, 32'h3);
        repeat (2) @(negedge clk);
        access(A_STATUS, 32'h1, 4'h1, dummy);
        wr(A_CTRL, 32'h0);
        rd_check("coll_match_wins", A_STATUS, 32'h1);
        wr(A_STATUS, 32'h1);
        rd_check("coll_w1c_after", A_STATUS, 32'h0);

`ifdef TIMER_PWM_EN
        wr(A_DUTY, 32'd3);
        rd_check("pwm_duty", A_DUTY, 32'd3);
        wr(A_PRESCALE, 32'd0);
        wr(A_COMPARE, 32'd9);
        wr(A_COUNT, 32'd0);
        wr(A_CTRL, 32'h3);
        repeat (10) @(negedge clk);
        pwm_high = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pwm_out) pwm_high++;
        end
        check("pwm_high_of_20", pwm_high, 6);
        wr(A_CTRL, 32'h0);
`else
        pwm_high = 0;
        wr(A_DUTY, 32'd3);
        rd_check("duty_absent", A_DUTY, 32'h0);
        repeat (5) begin
            @(negedge clk);
            if (pwm_out) pwm_high++;
        end
        check("pwm_tied_low", pwm_high, 0);
`endif

        // Out-of-window request: no ready, rdata holds
        rd_check("pre_miss_compare", A_COMPARE, 32'd3);
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0400_0000;
        iomem_wstrb = 4'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("miss_no_ready", {31'b0, iomem_ready}, 32'h0);
        end
        check("miss_rdata_hold", iomem_rdata, 32'd3);
        iomem_valid = 1'b0;

        // Reset during ACK drops ready at once and clears registers
        iomem_valid = 1'b1;
        iomem_addr  = A_COMPARE;
        @(negedge clk);
        check("mid_ready_up", {31'b0, iomem_ready}, 32'h1);
        rstn = 1'b0;
        #1;
        check("mid_ready_drop", {31'b0, iomem_ready}, 32'h0);
        iomem_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        rd_check("mid_compare_rst", A_COMPARE, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
